// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

    // Owner encodings double as the FSM state encoding so the debug
    // owner output is simply the state register.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = OWNER_NONE,
        OWN0 = OWNER_P0,
        OWN1 = OWNER_P1
    } arb_state_t;

    // Burst counter width; the counter saturates at its all-ones value.
    localparam int BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_SAT = {BURST_W{1'b1}};

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt);
        return (cnt == BURST_SAT) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker: preferred port wins unless its burst has expired.
// Latency: purely combinational, zero cycles.
// Backpressure: a non-picked requester simply sees no grant and must hold.
module dmem_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       prefer,   // 0 = port 0 first, 1 = port 1 first
    input  logic       exp0,     // port 0 has used up its burst
    input  logic       exp1,     // port 1 has used up its burst
    output logic [1:0] gnt       // one-hot (or zero) grant
);

    logic first1;

    // An expired preferred port hands first choice to the other one; it can
    // still win if the other port is not requesting.
    always_comb begin
        first1 = prefer ? !exp1 : exp0;
        gnt    = 2'b00;
        gnt[0] = req0 && (!first1 || !req1);
        gnt[1] = req1 && (first1 || !req0);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port data SRAM between two ports.
// Latency: gnt same cycle as req; SRAM controls one cycle after grant; read data two cycles after grant.
// Backpressure: ungranted requests must be held; no stall after grant, one access per cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,        // active-high synchronous reset despite the name
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem,
    output logic [1:0]        owner
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    arb_state_t         state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
    logic               rr, rr_nxt;        // 0 = p0 preferred on an IDLE conflict
    logic               pick_prefer;
    logic               exp0, exp1;
    logic [1:0]         pick_gnt;
    logic               gnt_any;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               rd_tag0, rd_tag1;

    // While a port owns the memory it keeps priority until its burst expires;
    // from IDLE the round-robin pointer decides.
    always_comb begin
        pick_prefer = rr;
        exp0        = 1'b0;
        exp1        = 1'b0;
        case (state)
            OWN0: begin
                pick_prefer = 1'b0;
                exp0        = (burst_cnt >= MAX_B);
            end
            OWN1: begin
                pick_prefer = 1'b1;
                exp1        = (burst_cnt >= MAX_B);
            end
            default: pick_prefer = rr;
        endcase
    end

    dmem_rr_pick u_pick (
        .req0   (p0_req),
        .req1   (p1_req),
        .prefer (pick_prefer),
        .exp0   (exp0),
        .exp1   (exp1),
        .gnt    (pick_gnt)
    );

    assign p0_gnt  = !rst_n && pick_gnt[0];
    assign p1_gnt  = !rst_n && pick_gnt[1];
    assign gnt_any = p0_gnt || p1_gnt;

    // Next-state, burst count and round-robin pointer from this cycle's grant.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        rr_nxt        = rr;
        if (p0_gnt) begin
            state_nxt     = OWN0;
            burst_cnt_nxt = (state == OWN0) ? burst_inc(burst_cnt) : BURST_W'(1);
            rr_nxt        = 1'b1;
        end else if (p1_gnt) begin
            state_nxt     = OWN1;
            burst_cnt_nxt = (state == OWN1) ? burst_inc(burst_cnt) : BURST_W'(1);
            rr_nxt        = 1'b0;
        end else begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr        <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            rr        <= rr_nxt;
        end
    end

    assign owner = state;

    // Mux the granted port's request fields towards the SRAM.
    always_comb begin
        sel_we    = p1_gnt ? p1_we    : p0_we;
        sel_addr  = p1_gnt ? p1_addr  : p0_addr;
        sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    end

    // Registered SRAM controls; address and write data hold through idle cycles.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            CEN      <= 1'b1;
            WEN      <= 1'b1;
            OEN      <= 1'b1;
            A        <= '0;
            Data2Mem <= '0;
        end else if (gnt_any) begin
            CEN      <= 1'b0;
            WEN      <= !sel_we;
            OEN      <= sel_we;
            A        <= sel_addr;
            Data2Mem <= sel_wdata;
        end else begin
            CEN      <= 1'b1;
            WEN      <= 1'b1;
            OEN      <= 1'b1;
        end
    end

    // Track which port owns an in-flight read; reset drops it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_tag0   <= 1'b0;
            rd_tag1   <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            rd_tag0   <= p0_gnt && !p0_we;
            rd_tag1   <= p1_gnt && !p1_we;
            p0_rvalid <= rd_tag0;
            p1_rvalid <= rd_tag1;
        end
    end

    // SRAM read data arrives in the rvalid cycle; qualified by rvalid only.
    assign p0_rdata = ReadDataMem;
    assign p1_rdata = ReadDataMem;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW   = 7;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem, ReadDataMem;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem), .owner(owner)
    );

    // SRAM environment: read data registered, valid the cycle after OEN=0.
    logic [DW-1:0] sram [128];
    always @(posedge clk) begin
        if (!CEN && !WEN) sram[A] <= Data2Mem;
        if (!CEN && !OEN) ReadDataMem <= sram[A];
    end

    // Reference model: memory contents in grant order, who owns the memory,
    // how long its current run is, and which port wins the next fresh conflict.
    logic [DW-1:0] ref_mem [128];
    int            m_own;      // -1 none, else port number
    int            m_run;
    int            m_pref;
    int            gcnt [2];
    logic          e_cen, e_wen, e_oen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_rv [2];
    logic [DW-1:0] e_rdat;
    logic          s1_rd [2];
    logic [DW-1:0] s1_dat;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming clock edge.
    task automatic check_cycle();
        int g;
        logic own_req, oth_req, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        chk("cen", CEN, e_cen);
        chk("wen", WEN, e_wen);
        chk("oen", OEN, e_oen);
        chk("addr", A, e_a);
        chk("data2mem", Data2Mem, e_d);
        chk("owner", owner, (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10));
        chk("p0_rvalid", p0_rvalid, e_rv[0]);
        chk("p1_rvalid", p1_rvalid, e_rv[1]);
        if (e_rv[0] && p0_rvalid) chk("p0_rdata", p0_rdata, e_rdat);
        if (e_rv[1] && p1_rvalid) chk("p1_rdata", p1_rdata, e_rdat);

        g = -1;
        if (!rst_n) begin
            if (m_own < 0) begin
                if (p0_req && p1_req) g = m_pref;
                else if (p0_req)      g = 0;
                else if (p1_req)      g = 1;
            end else begin
                own_req = (m_own == 0) ? p0_req : p1_req;
                oth_req = (m_own == 0) ? p1_req : p0_req;
                if (own_req && (!oth_req || m_run < MAXB)) g = m_own;
                else if (oth_req)                          g = 1 - m_own;
            end
        end
        chk("p0_gnt", p0_gnt, g == 0);
        chk("p1_gnt", p1_gnt, g == 1);
        chk("gnt_onehot", p0_gnt & p1_gnt, 1'b0);

        e_rv[0] = rst_n ? 1'b0 : s1_rd[0];
        e_rv[1] = rst_n ? 1'b0 : s1_rd[1];
        e_rdat  = s1_dat;
        s1_rd[0] = 1'b0;
        s1_rd[1] = 1'b0;
        if (rst_n) begin
            m_own = -1; m_run = 0; m_pref = 0;
            e_cen = 1; e_wen = 1; e_oen = 1; e_a = '0; e_d = '0;
        end else if (g >= 0) begin
            we = g ? p1_we : p0_we;
            ad = g ? p1_addr : p0_addr;
            wd = g ? p1_wdata : p0_wdata;
            e_cen = 0; e_wen = !we; e_oen = we; e_a = ad; e_d = wd;
            if (we) ref_mem[ad] = wd;
            else begin
                s1_rd[g] = 1'b1;
                s1_dat   = ref_mem[ad];
            end
            m_run  = (m_own == g) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_own  = g;
            m_pref = 1 - g;
            gcnt[g]++;
        end else begin
            e_cen = 1; e_wen = 1; e_oen = 1;
            m_own = -1; m_run = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            sram[i] = v;
            ref_mem[i] = v;
        end
        sram[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;

        rst_n = 1'b1;
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0);
        m_own = -1; m_run = 0; m_pref = 0;
        e_cen = 1; e_wen = 1; e_oen = 1; e_a = '0; e_d = '0;
        e_rv[0] = 0; e_rv[1] = 0; e_rdat = '0;
        s1_rd[0] = 0; s1_rd[1] = 0; s1_dat = '0;
        gcnt[0] = 0; gcnt[1] = 0;

        @(posedge clk); #1;
        // Requests during reset must never be granted.
        set_p0(1, 0, 7'h01, 32'h1);
        set_p1(1, 1, 7'h02, 32'h2);
        repeat (3) step();
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0);
        rst_n = 1'b0;
        step();

        // p0 read of word 5, then idle cycles holding A/Data2Mem.
        set_p0(1, 0, 7'h05, 32'hA5A5A5A5);
        step();
        set_p0(0, 1, 7'h33, 32'h0BADF00D);
        repeat (4) step();

        // p1 write then read-back of 0x10.
        set_p1(1, 1, 7'h10, 32'h12345678);
        step();
        set_p1(1, 0, 7'h10, 32'h0);
        step();
        set_p1(0, 0, '0, '0);
        repeat (3) step();

        // Both ports requesting continuously: 4/4/4 bursts.
        gcnt[0] = 0; gcnt[1] = 0;
        for (int i = 0; i < 12; i++) begin
            set_p0(1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
            set_p1(1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
            step();
        end
        chk("burst_p0_count", gcnt[0], 8);
        chk("burst_p1_count", gcnt[1], 4);
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0);
        repeat (3) step();

        // p0 alone: no burst cutoff.
        gcnt[0] = 0;
        for (int i = 0; i < 10; i++) begin
            set_p0(1, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
            step();
        end
        chk("p0_alone_count", gcnt[0], 10);
        set_p0(0, 0, '0, '0);
        repeat (3) step();

        // Reset the cycle after a read grant: the read is dropped.
        set_p0(1, 0, 7'h05, 32'h0);
        step();
        set_p0(0, 0, '0, '0);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        gcnt[0] = 0; gcnt[1] = 0;
        set_p0(1, 0, 7'h07, 32'h0);
        set_p1(1, 0, 7'h08, 32'h0);
        step();
        chk("post_reset_first_p0", gcnt[0], 1);
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0);
        repeat (3) step();

        // Randomized traffic over a small address window, rare resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) == 0);
            set_p0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom);
            set_p1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom);
            step();
        end
        rst_n = 1'b0;
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM (active-low CEN/WEN/OEN, 7-bit word address, 32-bit data) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/loader path.
- Arbitration is round-robin with a bounded burst, using a req/gnt handshake.
- SRAM controls are registered. Reads return data a fixed 2 cycles after grant.

Parameters:
- ADDR_W, 7, SRAM word-address width
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; synchronous, active-high (1 = reset)
- p0_req  in  1  port 0 access request, level
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_W  word address
- p0_wdata  in  DATA_W  write data
- p0_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid  out  1  p0_rdata valid this cycle
- p0_rdata  out  DATA_W  read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0
- CEN  out  1  SRAM chip enable, active-low
- WEN  out  1  SRAM write enable, active-low
- OEN  out  1  SRAM output enable, active-low
- A  out  ADDR_W  SRAM address
- Data2Mem  out  DATA_W  SRAM write data
- ReadDataMem  in  DATA_W  SRAM read data, valid the cycle after OEN=0
- owner  out  2  current owner: 00 none, 01 p0, 10 p1 (debug visibility)

Behaviour:
- Reset values:
  - state IDLE, rr pointer = p0 preferred, burst_cnt = 0.
  - CEN = WEN = OEN = 1, A = 0, Data2Mem = 0.
  - p0_rvalid = p1_rvalid = 0, owner = 00.
  - Both gnt forced 0 while rst_n = 1.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE:
    - A single requester is granted.
    - If both request, grant the port the rr pointer prefers.
    - Go to OWNx with burst_cnt = 1.
  - OWNx:
    - If px_req and (other port idle, or burst_cnt < MAX_BURST): grant px, burst_cnt++ (saturating at 15).
    - Otherwise, if the other port requests: grant it, move to OWN(other), burst_cnt = 1.
    - Otherwise (no request): return to IDLE with no grant.
  - rr pointer updates on every grant to prefer the non-granted port.
- Handshake:
  - gnt is combinational from the registered state and the current req inputs.
  - The transfer occurs in the cycle where req && gnt.
  - A requester may change we/addr/wdata freely after gnt.
  - A request not granted must be held; a dropped request is simply not served.
- Pipeline, with grant in cycle t:
  - t+1: registered CEN = 0, A = addr, Data2Mem = wdata.
  - t+1 write: WEN = 0, OEN = 1.
  - t+1 read: WEN = 1, OEN = 0.
  - t+2, read only: px_rvalid = 1 for exactly one cycle. px_rdata = ReadDataMem, qualified by rvalid; its value is don't-care otherwise.
  - Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back grants are allowed, including a read followed by a write to the same address.
- Cycles with no grant: CEN = WEN = OEN = 1; A and Data2Mem hold their last values.
- The owner output reflects the registered FSM state.
- Reset mid-read: a read granted in t with reset in t+1 gives rvalid = 0 in t+2; the in-flight access is dropped.
- Simultaneous read and write grants are impossible; at most one gnt is high per cycle.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE/OWN0/OWN1);
  - the owner encodings;
  - the burst counter width constant (4 bits).
- Sub-module dmem_rr_pick: a combinational two-way picker (inputs: req0, req1, prefer, burst-expired flags; outputs: one-hot grant). It is reused by the instruction-side arbiter later.

Test Plan:
- p0 read, addr 7'h05, SRAM word 5 = 32'hDEADBEEF:
  - p0_gnt in t;
  - CEN = 0, OEN = 0, A = 5 in t+1;
  - p0_rvalid = 1, p0_rdata = DEADBEEF in t+2.
- p1 write, addr 7'h10, data 32'h12345678 at t → CEN = 0, WEN = 0, A = 16, Data2Mem = 12345678 in t+1, no rvalid. A p1 read of 7'h10 at t+1 returns 12345678 at t+3.
- Both reqs held continuously from reset, MAX_BURST = 4:
  - grant pattern p0 ×4, p1 ×4, p0 ×4;
  - owner toggles 01/10 accordingly;
  - never both gnt high.
- p0 req alone for 10 cycles (p1 idle): p0_gnt high all 10 cycles with no burst cutoff; then req drops → owner 00, CEN = 1.
- p0 read granted at t, rst_n = 1 in t+1:
  - p0_rvalid = 0 at t+2;
  - CEN = WEN = OEN = 1, A = 0 after reset;
  - first post-reset conflict is granted to p0.
- Idle cycles between accesses: A/Data2Mem hold their previous values and CEN/WEN/OEN are all 1.
